// File: rtl/vec_seq_pkg.sv
// Shared types and constants for the vector issue sequencer slice.
package vec_seq_pkg;
   localparam int ALU_CTRL_W    = 3;
   localparam int MAX_ELEMS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MEM  = 2'd2,
      DONE = 2'd3
   } seq_state_t;
endpackage

// File: rtl/vector_issue_sequencer_if.sv
// Control-unit inputs and element-datapath outputs of the vector issue sequencer.
interface vector_issue_sequencer_if #(
   parameter int MAX_ELEMS = vec_seq_pkg::MAX_ELEMS_DEF,
   parameter int IDX_W     = $clog2(MAX_ELEMS)
) ();
   logic                                issue_valid;
   logic                                vectorial;
   logic                                RegWrite;
   logic                                MemWrite;
   logic                                ResultSrc;
   logic [vec_seq_pkg::ALU_CTRL_W-1:0]  ALUControl;
   logic [IDX_W:0]                      vl;
   logic                                flush;
   logic                                mem_ack;

   logic                                stall;
   logic                                busy;
   logic                                elem_valid;
   logic [IDX_W-1:0]                    elem_idx;
   logic                                elem_we;
   logic [vec_seq_pkg::ALU_CTRL_W-1:0]  alu_ctrl_o;
   logic                                mem_req;
   logic                                mem_we;
   logic                                done;

   modport master (
      output issue_valid, vectorial, RegWrite, MemWrite, ResultSrc, ALUControl, vl, flush, mem_ack,
      input  stall, busy, elem_valid, elem_idx, elem_we, alu_ctrl_o, mem_req, mem_we, done
   );

   modport slave (
      input  issue_valid, vectorial, RegWrite, MemWrite, ResultSrc, ALUControl, vl, flush, mem_ack,
      output stall, busy, elem_valid, elem_idx, elem_we, alu_ctrl_o, mem_req, mem_we, done
   );
endinterface

// File: rtl/vec_elem_counter.sv
// Element index counter: clamps the vector length at load and saturates at the last element.
module vec_elem_counter #(
   parameter int MAX_ELEMS = 8,
   parameter int IDX_W     = $clog2(MAX_ELEMS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [IDX_W:0]   vl,
   input  logic             inc,
   output logic [IDX_W-1:0] idx,
   output logic             is_last,
   output logic             len_zero
);
   localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(MAX_ELEMS);

   logic [IDX_W:0]   len_q;
   logic [IDX_W:0]   len_c;
   logic [IDX_W-1:0] idx_q;

   assign len_c    = (vl > MAX_LEN) ? MAX_LEN : vl;
   assign len_zero = (vl == '0);
   assign is_last  = ({1'b0, idx_q} == (len_q - (IDX_W+1)'(1)));
   assign idx      = idx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q <= '0;
         idx_q <= '0;
      end else if (load) begin
         len_q <= len_c;
         idx_q <= '0;
      end else if (inc && !is_last) begin
         idx_q <= idx_q + 1'b1;
      end
   end
endmodule

// File: rtl/vector_issue_sequencer.sv
// Steps a decoded vector instruction through the shared ALU/memory datapath one element at a time.
//
// state | meaning
// IDLE  | no vector instruction; scalars pass with no stall
// EXEC  | issue current element (ALU op, or memory request)
// MEM   | memory request outstanding, waiting for mem_ack
// DONE  | one-cycle retire pulse, fetch released
module vector_issue_sequencer
   import vec_seq_pkg::*;
#(
   parameter int MAX_ELEMS = MAX_ELEMS_DEF,
   parameter int IDX_W     = $clog2(MAX_ELEMS)
) (
   input logic                     clk,
   input logic                     rst,
   vector_issue_sequencer_if.slave bus
);
   seq_state_t            state_q, state_d;
   logic                  regwrite_q, memwrite_q, resultsrc_q, flush_pend_q;
   logic [ALU_CTRL_W-1:0] aluctrl_q;

   logic             accept, mem_op, abandon;
   logic             cnt_load, cnt_inc, is_last, len_zero;
   logic [IDX_W-1:0] idx;

   vec_elem_counter #(.MAX_ELEMS(MAX_ELEMS), .IDX_W(IDX_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .vl       (bus.vl),
      .inc      (cnt_inc),
      .idx      (idx),
      .is_last  (is_last),
      .len_zero (len_zero)
   );

   assign accept  = bus.issue_valid && bus.vectorial && !bus.flush;
   assign mem_op  = memwrite_q || resultsrc_q;
   assign abandon = flush_pend_q || bus.flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         regwrite_q   <= 1'b0;
         memwrite_q   <= 1'b0;
         resultsrc_q  <= 1'b0;
         aluctrl_q    <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         // a flush seen while the access is outstanding is honoured only once it acks
         flush_pend_q <= (state_d == MEM) && (flush_pend_q || bus.flush);
         if (cnt_load) begin
            regwrite_q  <= bus.RegWrite;
            memwrite_q  <= bus.MemWrite;
            resultsrc_q <= bus.ResultSrc;
            aluctrl_q   <= bus.ALUControl;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_load       = 1'b0;
      cnt_inc        = 1'b0;
      bus.stall      = 1'b0;
      bus.elem_valid = 1'b0;
      bus.elem_we    = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               bus.stall = 1'b1;
               cnt_load  = 1'b1;
               state_d   = len_zero ? DONE : EXEC;
            end
         end
         EXEC: begin
            bus.stall = 1'b1;
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               bus.elem_valid = 1'b1;
               if (!mem_op) begin
                  bus.elem_we = regwrite_q;
                  cnt_inc     = 1'b1;
                  state_d     = is_last ? DONE : EXEC;
               end else begin
                  bus.mem_req = 1'b1;
                  bus.mem_we  = memwrite_q;
                  if (bus.mem_ack) begin
                     bus.elem_we = resultsrc_q && regwrite_q;
                     cnt_inc     = 1'b1;
                     state_d     = is_last ? DONE : EXEC;
                  end else begin
                     state_d = MEM;
                  end
               end
            end
         end
         MEM: begin
            bus.stall      = 1'b1;
            bus.elem_valid = 1'b1;
            bus.mem_req    = 1'b1;
            bus.mem_we     = memwrite_q;
            if (bus.mem_ack) begin
               bus.elem_we = resultsrc_q && regwrite_q && !abandon;
               if (abandon) begin
                  state_d = IDLE;
               end else begin
                  cnt_inc = 1'b1;
                  state_d = is_last ? DONE : EXEC;
               end
            end
         end
         DONE: begin
            bus.done = !bus.flush;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.elem_idx   = idx;
   assign bus.alu_ctrl_o = aluctrl_q;
endmodule
